// File: rtl/qubit_swap_unit_pkg.sv
// Shared definitions for the qubit swap stage: gate mode encodings and the
// default amplitude component width.
package qubit_swap_unit_pkg;

  localparam int TOTAL_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_SWAP  = 2'b01,
    MODE_CSWAP = 2'b10,
    MODE_RSVD  = 2'b11
  } qmode_e;

endpackage

// File: rtl/qubit_swap_unit_swap_index_perm.sv
// Source-index generator: for output index j, returns p(j), which is j with
// bits qa and qb exchanged, optionally gated by bit qc of j.
module swap_index_perm
  import qubit_swap_unit_pkg::*;
#(
  parameter int N_QUBITS = 3,
  parameter int IDX_W    = 3
) (
  input  logic [N_QUBITS-1:0] j,
  input  logic [IDX_W-1:0]    qa,
  input  logic [IDX_W-1:0]    qb,
  input  logic [IDX_W-1:0]    qc,
  input  logic [1:0]          mode,
  output logic [N_QUBITS-1:0] p
);

  logic                ba, bb, bc;
  logic [N_QUBITS-1:0] swapped;

  // Selects are matched against each bit position rather than used as
  // indices, so out-of-range selects can never address past j.
  always_comb begin
    ba      = 1'b0;
    bb      = 1'b0;
    bc      = 1'b0;
    swapped = j;
    for (int i = 0; i < N_QUBITS; i++) begin
      if (int'(qa) == i) ba = j[i];
      if (int'(qb) == i) bb = j[i];
      if (int'(qc) == i) bc = j[i];
    end
    for (int i = 0; i < N_QUBITS; i++) begin
      if (int'(qa) == i) swapped[i] = bb;
      if (int'(qb) == i) swapped[i] = ba;
    end
    p = j;
    if (mode == MODE_SWAP || (mode == MODE_CSWAP && bc)) p = swapped;
  end

endmodule

// File: rtl/qubit_swap_unit.sv
// N-qubit state-vector swap / controlled-swap stage with a one-deep output
// register, valid/ready handshake and a saturating transaction counter.
module qubit_swap_unit
  import qubit_swap_unit_pkg::*;
#(
  parameter int N_QUBITS = 3,
  parameter int DATA_W   = TOTAL_WIDTH,
  parameter int IDX_W    = 3,
  parameter int CNT_W    = 16,
  localparam int DIM     = 1 << N_QUBITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIM*DATA_W-1:0] in_re,
  input  logic [DIM*DATA_W-1:0] in_im,
  input  logic [1:0]            mode,
  input  logic [IDX_W-1:0]      qa,
  input  logic [IDX_W-1:0]      qb,
  input  logic [IDX_W-1:0]      qc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIM*DATA_W-1:0] out_re,
  output logic [DIM*DATA_W-1:0] out_im,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      txn_count
);

  localparam logic [IDX_W:0] NQ = (IDX_W + 1)'(N_QUBITS);

  function automatic logic cfg_illegal(input logic [1:0] m, input logic [IDX_W-1:0] a,
                                       input logic [IDX_W-1:0] b, input logic [IDX_W-1:0] c);
    logic bad_ab;
    bad_ab = ({1'b0, a} >= NQ) || ({1'b0, b} >= NQ);
    case (m)
      MODE_SWAP:  cfg_illegal = bad_ab;
      MODE_CSWAP: cfg_illegal = bad_ab || ({1'b0, c} >= NQ) || (c == a) || (c == b);
      MODE_RSVD:  cfg_illegal = 1'b1;
      default:    cfg_illegal = 1'b0;
    endcase
  endfunction

  logic                               bad;
  logic [1:0]                         eff_mode;
  logic [DIM-1:0][N_QUBITS-1:0]       pidx;
  logic [DATA_W-1:0]                  in_re_a [DIM];
  logic [DATA_W-1:0]                  in_im_a [DIM];
  logic [DIM*DATA_W-1:0]              perm_re, perm_im;
  logic                               in_fire, out_fire;

  assign bad      = cfg_illegal(mode, qa, qb, qc);
  assign eff_mode = bad ? MODE_PASS : mode;
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  for (genvar k = 0; k < DIM; k++) begin : g_lane
    localparam logic [N_QUBITS-1:0] JK = N_QUBITS'(k);
    assign in_re_a[k] = in_re[k*DATA_W +: DATA_W];
    assign in_im_a[k] = in_im[k*DATA_W +: DATA_W];
    swap_index_perm #(.N_QUBITS(N_QUBITS), .IDX_W(IDX_W)) u_perm (
      .j(JK), .qa(qa), .qb(qb), .qc(qc), .mode(eff_mode), .p(pidx[k])
    );
    assign perm_re[k*DATA_W +: DATA_W] = in_re_a[pidx[k]];
    assign perm_im[k*DATA_W +: DATA_W] = in_im_a[pidx[k]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      cfg_err   <= 1'b0;
      txn_count <= '0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_re    <= perm_re;
        out_im    <= perm_im;
        cfg_err   <= bad;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_fire && txn_count != {CNT_W{1'b1}}) txn_count <= txn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_qubit_swap_unit.sv
// Directed bench for qubit_swap_unit (N_QUBITS=3, 16-bit amplitudes).
module tb_qubit_swap_unit;

  localparam int N = 3;
  localparam int DW = 16;
  localparam int DIM = 8;
  localparam int VW = DIM * DW;

  // Hand-derived source-index tables, entry [j] = p(j)
  localparam logic [7:0][2:0] P_ID   = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [7:0][2:0] P_SW02 = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};
  localparam logic [7:0][2:0] P_CS   = {3'd7, 3'd3, 3'd5, 3'd4, 3'd6, 3'd2, 3'd1, 3'd0};

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, cfg_err;
  logic [VW-1:0] in_re, in_im, out_re, out_im, exp_re, exp_im;
  logic [1:0]    mode;
  logic [2:0]    qa, qb, qc;
  logic [15:0]   txn_count;

  int n_vec = 0;
  int n_err = 0;

  qubit_swap_unit #(.N_QUBITS(N), .DATA_W(DW), .IDX_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .mode(mode), .qa(qa), .qb(qb), .qc(qc),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .cfg_err(cfg_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Amplitude k of seed s: re = k*0x100 + s, im = 16*s - k
  function automatic void build(input logic [7:0][2:0] p, input int s,
                                output logic [VW-1:0] re, output logic [VW-1:0] im);
    for (int k = 0; k < DIM; k++) begin
      re[k*DW +: DW] = 16'(int'(p[k]) * 256 + s);
      im[k*DW +: DW] = 16'(s * 16 - int'(p[k]));
    end
  endfunction

  task automatic drive(input logic [1:0] m, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input int s);
    logic [VW-1:0] r, i;
    build(P_ID, s, r, i);
    in_re = r; in_im = i; mode = m; qa = a; qb = b; qc = c; in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 3'd0, 3'd0, 3'd0, 0); in_valid = 1'b0;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_vec++; if (out_re !== '0 || out_im !== '0) begin n_err++; $display("FAIL reset_data got %h/%h exp 0", out_re, out_im); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
    n_vec++; if (txn_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", txn_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_legacy_swap();
    out_ready = 1'b1;
    drive(2'b01, 3'd0, 3'd2, 3'd0, 0);
    tick(); in_valid = 1'b0;
    build(P_SW02, 0, exp_re, exp_im);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL legacy_valid got %b exp 1", out_valid); end
    n_vec++; if (out_re !== exp_re) begin n_err++; $display("FAIL legacy_re got %h exp %h", out_re, exp_re); end
    n_vec++; if (out_im !== exp_im) begin n_err++; $display("FAIL legacy_im got %h exp %h", out_im, exp_im); end
    n_vec++; if (out_re[1*DW +: DW] !== 16'h0400) begin n_err++; $display("FAIL legacy_re1 got %h exp 0400", out_re[1*DW +: DW]); end
    n_vec++; if (out_re[4*DW +: DW] !== 16'h0100) begin n_err++; $display("FAIL legacy_re4 got %h exp 0100", out_re[4*DW +: DW]); end
    n_vec++; if (out_re[3*DW +: DW] !== 16'h0600) begin n_err++; $display("FAIL legacy_re3 got %h exp 0600", out_re[3*DW +: DW]); end
    n_vec++; if (out_re[6*DW +: DW] !== 16'h0300) begin n_err++; $display("FAIL legacy_re6 got %h exp 0300", out_re[6*DW +: DW]); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL legacy_cfg_err got %b exp 0", cfg_err); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL legacy_idle got %b exp 0", out_valid); end
    n_vec++; if (txn_count !== 16'd1) begin n_err++; $display("FAIL legacy_count got %0d exp 1", txn_count); end
  endtask

  task automatic test_cswap();
    drive(2'b10, 3'd0, 3'd2, 3'd1, 0);
    tick(); in_valid = 1'b0;
    build(P_CS, 0, exp_re, exp_im);
    n_vec++; if (out_re !== exp_re) begin n_err++; $display("FAIL cswap_re got %h exp %h", out_re, exp_re); end
    n_vec++; if (out_im !== exp_im) begin n_err++; $display("FAIL cswap_im got %h exp %h", out_im, exp_im); end
    n_vec++; if (out_re[1*DW +: DW] !== 16'h0100) begin n_err++; $display("FAIL cswap_re1 got %h exp 0100", out_re[1*DW +: DW]); end
    n_vec++; if (out_re[3*DW +: DW] !== 16'h0600) begin n_err++; $display("FAIL cswap_re3 got %h exp 0600", out_re[3*DW +: DW]); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cswap_cfg_err got %b exp 0", cfg_err); end
    tick();
    n_vec++; if (txn_count !== 16'd2) begin n_err++; $display("FAIL cswap_count got %0d exp 2", txn_count); end
  endtask

  task automatic test_illegal();
    logic [1:0] m [4]   = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [2:0] a [4]   = '{3'd3, 3'd0, 3'd0, 3'd1};
    logic [2:0] b [4]   = '{3'd0, 3'd2, 3'd2, 3'd1};
    logic [2:0] c [4]   = '{3'd1, 3'd0, 3'd1, 3'd0};
    logic       err [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      drive(m[v], a[v], b[v], c[v], v + 1);
      tick();
      build(P_ID, v + 1, exp_re, exp_im);
      n_vec++; if (out_valid !== 1'b1 || out_re !== exp_re || out_im !== exp_im) begin
        n_err++; $display("FAIL illegal_data[%0d] got v=%b %h exp v=1 %h", v, out_valid, out_re, exp_re);
      end
      n_vec++; if (cfg_err !== err[v]) begin n_err++; $display("FAIL illegal_cfg_err[%0d] got %b exp %b", v, cfg_err, err[v]); end
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (txn_count !== 16'd6) begin n_err++; $display("FAIL illegal_count got %0d exp 6", txn_count); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] r1, i1, r2, i2;
    build(P_SW02, 5, r1, i1);
    build(P_CS, 9, r2, i2);
    out_ready = 1'b0;
    drive(2'b01, 3'd0, 3'd2, 3'd0, 5);
    tick();
    drive(2'b10, 3'd0, 3'd2, 3'd1, 9);
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (out_valid !== 1'b1 || out_re !== r1 || out_im !== i1) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%b %h exp v=1 %h", c, out_valid, out_re, r1);
      end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b exp 0", c, in_ready); end
      n_vec++; if (txn_count !== 16'd6) begin n_err++; $display("FAIL stall_count[%0d] got %0d exp 6", c, txn_count); end
      tick();
    end
    out_ready = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    tick(); in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_re !== r2 || out_im !== i2) begin
      n_err++; $display("FAIL second_vec got v=%b %h exp v=1 %h", out_valid, out_re, r2);
    end
    n_vec++; if (txn_count !== 16'd7) begin n_err++; $display("FAIL release_count1 got %0d exp 7", txn_count); end
    tick();
    n_vec++; if (txn_count !== 16'd8 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL release_count2 got %0d v=%b exp 8 v=0", txn_count, out_valid);
    end
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      drive(2'b01, 3'd0, 3'd2, 3'd0, 16 + v);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL tput_in_ready[%0d] got %b exp 1", v, in_ready); end
      tick();
      build(P_SW02, 16 + v, exp_re, exp_im);
      n_vec++; if (out_valid !== 1'b1 || out_re !== exp_re || out_im !== exp_im) begin
        n_err++; $display("FAIL tput_data[%0d] got v=%b %h exp v=1 %h", v, out_valid, out_re, exp_re);
      end
      n_vec++; if (txn_count !== 16'(8 + v)) begin n_err++; $display("FAIL tput_count[%0d] got %0d exp %0d", v, txn_count, 8 + v); end
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (txn_count !== 16'd16) begin n_err++; $display("FAIL tput_total got %0d exp 16", txn_count); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive(2'b01, 3'd1, 3'd2, 3'd0, 3);
    tick(); in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL prestall_valid got %b exp 1", out_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (out_valid !== 1'b0 || out_re !== '0 || out_im !== '0) begin
      n_err++; $display("FAIL midrst_out got v=%b %h/%h exp v=0 0/0", out_valid, out_re, out_im);
    end
    n_vec++; if (txn_count !== 16'd0) begin n_err++; $display("FAIL midrst_count got %0d exp 0", txn_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_legacy_swap();
    test_cswap();
    test_illegal();
    test_backpressure();
    test_throughput();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qubit_swap_unit.md
Name: qubit_swap_unit

Overview:
Parametrised successor of the fixed 3-qubit q0/q2 swap stage. It permutes a full N-qubit state vector of complex fixed-point amplitudes by swapping any two runtime-selected qubits. It also supports a controlled-swap (Fredkin) mode and pass-through. The block sits between QFT gate stages and carries a valid/ready handshake and a one-deep output register with stall support.

Parameters:
N_QUBITS, 3, number of qubits; vector length DIM = 2**N_QUBITS (legal range 2..6)
DATA_W, `TOTAL_WIDTH, width of each real/imag amplitude component (signed fixed point)
IDX_W, 3, width of qubit-select fields; must satisfy 2**IDX_W >= N_QUBITS
CNT_W, 16, width of completed-transaction counter

Ports:
clk  in  1  single clock; all logic is clocked on the rising edge
rst_n  in  1  reset, synchronous and active-low
in_valid  in  1  input vector and config are valid
in_ready  out  1  block can accept the input this cycle
in_re  in  DIM*DATA_W  real parts; amplitude k is at slice [k*DATA_W +: DATA_W]
in_im  in  DIM*DATA_W  imaginary parts, same packing as in_re
mode  in  2  00 pass, 01 swap, 10 controlled swap, 11 reserved
qa  in  IDX_W  first qubit to swap
qb  in  IDX_W  second qubit to swap
qc  in  IDX_W  control qubit (used in mode 10 only)
out_valid  out  1  output vector is valid
out_ready  in  1  downstream accepts the output
out_re  out  DIM*DATA_W  permuted real parts
out_im  out  DIM*DATA_W  permuted imaginary parts
cfg_err  out  1  the transaction on the output had an illegal config; qualified by out_valid
txn_count  out  CNT_W  number of completed output handshakes, saturating

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - out_valid=0, out_re=0, out_im=0, cfg_err=0, txn_count=0.
  - A transaction in flight is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle. Data accepted at edge t appears with out_valid=1 after edge t.
  - Simultaneous output and input transfer: the register reloads in the same cycle, so full throughput is one vector per cycle.
- Stall: while out_valid && !out_ready, out_re, out_im and cfg_err hold stable.
- Idle: out_valid clears after an output transfer with no new input; data is retained but is don't-care.
- Config is sampled only on the input transfer; it is not stored separately.
- Permutation: out[j] = in[p(j)]. p(j) is j with bits qa and qb exchanged.
  - Mode 01: p is applied to all j.
  - Mode 10: p is applied only when bit qc of j is 1; otherwise p(j)=j.
  - Mode 00: p(j)=j.
  - Real and imaginary parts move together. No arithmetic is performed; values are bit-exact.
- Config checks:
  - qa==qb (legal) gives the identity.
  - Illegal config forces pass-through and cfg_err=1 for that transaction. Illegal means any of:
    - mode 11;
    - qa>=N_QUBITS or qb>=N_QUBITS in modes 01/10;
    - qc>=N_QUBITS, qc==qa or qc==qb in mode 10.
- txn_count: increments on each output transfer and saturates at 2**CNT_W-1.
- With N_QUBITS=3, mode 01, qa=0, qb=2, the output equals the legacy fixed swap, plus a 1-cycle register and handshake.

Decomposition:
- Shared header (qgate_params.vh, alongside fixed_point_params.vh) holds:
  - mode encodings MODE_PASS/MODE_SWAP/MODE_CSWAP/MODE_RSVD;
  - the amplitude slice macro.
- Sub-module swap_index_perm:
  - combinational; input j, qa, qb, qc, mode; output p(j);
  - instantiated DIM times with a generate loop.
- A config-check function sits in the top module.
- The top module holds the output register, handshake and counter.

Test Plan:
- Legacy equivalence:
  - Stimulus: N=3, mode 01, qa=0, qb=2, in_re[k]=k*16'h0100, in_im[k]=-k.
  - Response: out_re[1]=16'h0400, out_re[4]=16'h0100, out_re[3]=16'h0600, out_re[6]=16'h0300, indices 0, 2, 5, 7 unchanged, in_im permuted identically, out_valid 1 cycle after accept.
- Controlled swap:
  - Stimulus: mode 10, qc=1, qa=0, qb=2, same data.
  - Response: out_re[3]=16'h0600, out_re[6]=16'h0300, out_re[1]=16'h0100, out_re[4]=16'h0400 (unswapped), cfg_err=0.
- Backpressure:
  - Stimulus: two back-to-back vectors, out_ready=0 for 3 cycles.
  - Response: first output held stable, in_ready=0 during the stall, second vector not lost, txn_count goes 0→1→2 after release.
- Illegal config:
  - Stimulus: mode 01 with qa=3; also mode 10 with qc=qa=0.
  - Response: output equals input, cfg_err=1 with out_valid; a following legal vector shows cfg_err=0.
- Full throughput:
  - Stimulus: 8 consecutive vectors, in_valid=1, out_ready=1.
  - Response: in_ready stays 1, 8 outputs on 8 consecutive cycles, txn_count=8.
- Reset mid-stall:
  - Stimulus: out_valid=1, out_ready=0, then rst_n=0 for one edge.
  - Response: out_valid=0, out_re=out_im=0, txn_count=0 after that edge, in_ready=1.
